// File: rtl/int_dispatch.sv
// Interrupt controller for the SM83 core: IF/IE registers, IME with EI delay,
// HALT wake-up and the 5-M-cycle dispatch sequencer that places the vector on bro.
module int_dispatch (
    input  logic       CLK,
    input  logic       RES,
    input  logic       mstep,
    input  logic       fetch_boundary,
    input  logic [4:0] irq_set,
    input  logic       if_we,
    input  logic       ie_we,
    input  logic [7:0] wdata,
    output logic [7:0] if_rdata,
    output logic [7:0] ie_rdata,
    input  logic       op_ei,
    input  logic       op_di,
    input  logic       op_reti,
    input  logic       op_halt,
    output logic       int_req,
    output logic [2:0] disp_state,
    output logic [4:0] bro,
    output logic       ime,
    output logic       halted,
    output logic       halt_bug
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_D1   = 3'd1;
    localparam logic [2:0] S_D3   = 3'd3;
    localparam logic [2:0] S_D4   = 3'd4;
    localparam logic [2:0] S_D5   = 3'd5;

    logic [4:0] if_q;
    logic [7:0] ie_q;
    logic       ei_pend;
    logic [2:0] state;
    logic [4:0] vec_q;
    logic [4:0] masked;
    logic       pending;
    logic       take;
    logic [2:0] vec_idx;
    logic       vec_hit;
    logic [4:0] ack_mask;

    assign masked     = if_q & ie_q[4:0];
    assign pending    = |masked;
    assign take       = (state == S_IDLE) && fetch_boundary && ime && pending;
    assign int_req    = mstep && take;
    assign if_rdata   = {3'b111, if_q};
    assign ie_rdata   = ie_q;
    assign disp_state = state;

    // Lowest index wins.
    always_comb begin
        vec_idx = 3'd0;
        vec_hit = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (masked[i]) begin
                vec_idx = 3'(i);
                vec_hit = 1'b1;
            end
        end
    end

    always_comb begin
        ack_mask = 5'd0;
        if (mstep && (state == S_D3) && vec_hit)
            ack_mask = 5'b00001 << vec_idx;
    end

    // A request arriving in the same CLK beats both a write and the acknowledge.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            if_q <= 5'd0;
            ie_q <= 8'd0;
        end else begin
            if_q <= ((if_we ? wdata[4:0] : if_q) & ~ack_mask) | irq_set;
            if (ie_we)
                ie_q <= wdata;
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state <= S_IDLE;
        end else if (mstep) begin
            if (state == S_IDLE) begin
                if (take)
                    state <= S_D1;
            end else if (state == S_D5) begin
                state <= S_IDLE;
            end else begin
                state <= state + 3'd1;
            end
        end
    end

    // Vector is frozen at the end of D3 so IE writes by the PCH push can cancel it.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            vec_q <= 5'd0;
            bro   <= 5'd0;
        end else if (mstep) begin
            if (state == S_D3)
                vec_q <= vec_hit ? {2'b01, vec_idx} : 5'd0;
            bro <= (state == S_D4) ? vec_q : 5'd0;
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            ime     <= 1'b0;
            ei_pend <= 1'b0;
        end else if (mstep) begin
            if (take || op_di) begin
                ime     <= 1'b0;
                ei_pend <= 1'b0;
            end else begin
                if (op_reti || (fetch_boundary && ei_pend))
                    ime <= 1'b1;
                if (op_ei)
                    ei_pend <= 1'b1;
                else if (fetch_boundary)
                    ei_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            halted   <= 1'b0;
            halt_bug <= 1'b0;
        end else if (mstep) begin
            halt_bug <= op_halt && pending && !ime;
            if (op_halt && !pending)
                halted <= 1'b1;
            else if (halted && pending)
                halted <= 1'b0;
        end
    end
endmodule

// File: tb/tb_int_dispatch.sv
// Self-checking bench for int_dispatch: randomized register/dispatch traffic
// against a small behavioural model of IF, IE and IME.
module tb_int_dispatch;
    logic       CLK = 1'b0;
    logic       RES = 1'b0;
    logic       mstep = 1'b0, fetch_boundary = 1'b0;
    logic [4:0] irq_set = 5'd0;
    logic       if_we = 1'b0, ie_we = 1'b0;
    logic [7:0] wdata = 8'd0;
    logic       op_ei = 1'b0, op_di = 1'b0, op_reti = 1'b0, op_halt = 1'b0;
    logic [7:0] if_rdata, ie_rdata;
    logic       int_req;
    logic [2:0] disp_state;
    logic [4:0] bro;
    logic       ime, halted, halt_bug;

    int checks = 0;
    int failures = 0;
    logic [4:0] m_if;
    logic [7:0] m_ie;
    logic       m_ime;
    logic       last_req;

    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_EI   = 4'b1000;
    localparam logic [3:0] OP_DI   = 4'b0100;
    localparam logic [3:0] OP_RETI = 4'b0010;
    localparam logic [3:0] OP_HALT = 4'b0001;

    always #5 CLK = ~CLK;

    int_dispatch dut (
        .CLK(CLK), .RES(RES), .mstep(mstep), .fetch_boundary(fetch_boundary),
        .irq_set(irq_set), .if_we(if_we), .ie_we(ie_we), .wdata(wdata),
        .if_rdata(if_rdata), .ie_rdata(ie_rdata),
        .op_ei(op_ei), .op_di(op_di), .op_reti(op_reti), .op_halt(op_halt),
        .int_req(int_req), .disp_state(disp_state), .bro(bro), .ime(ime),
        .halted(halted), .halt_bug(halt_bug)
    );

    task automatic clk1();
        @(posedge CLK);
        #1;
    endtask

    task automatic step(input logic fb, input logic [3:0] ops);
        mstep = 1'b1;
        fetch_boundary = fb;
        {op_ei, op_di, op_reti, op_halt} = ops;
        #3 last_req = int_req;
        clk1();
        mstep = 1'b0;
        fetch_boundary = 1'b0;
        {op_ei, op_di, op_reti, op_halt} = OP_NONE;
    endtask

    task automatic write_if(input logic [7:0] v);
        if_we = 1'b1; wdata = v;
        clk1();
        if_we = 1'b0;
        m_if = v[4:0];
    endtask

    task automatic write_ie(input logic [7:0] v);
        ie_we = 1'b1; wdata = v;
        clk1();
        ie_we = 1'b0;
        m_ie = v;
    endtask

    task automatic pulse_set(input logic [4:0] s);
        irq_set = s;
        clk1();
        irq_set = 5'd0;
        m_if = m_if | s;
    endtask

    task automatic set_ime(input logic v);
        step(1'b0, v ? OP_RETI : OP_DI);
        m_ime = v;
    endtask

    function automatic int lowest(input logic [4:0] m);
        for (int i = 0; i < 5; i++)
            if (m[i]) return i;
        return -1;
    endfunction

    // Boundary check followed, when the model says so, by a full 5-step dispatch.
    task automatic run_dispatch(input string tag);
        logic [4:0] hits;
        logic [7:0] vec;
        logic       exp_req;
        int         idx;
        hits = m_if & m_ie[4:0];
        exp_req = m_ime && (hits != 5'd0);
        step(1'b1, OP_NONE);
        checks++;
        if (last_req !== exp_req) begin
            failures++;
            $display("FAIL %s int_req got=%b want=%b", tag, last_req, exp_req);
        end
        if (exp_req) begin
            m_ime = 1'b0;
            idx = lowest(hits);
            vec = 8'h40 + 8'(idx * 8);
            for (int k = 1; k <= 5; k++) begin
                repeat ($urandom_range(0, 2)) clk1();
                checks++;
                if (disp_state !== 3'(k)) begin
                    failures++;
                    $display("FAIL %s disp_state got=%0d want=%0d", tag, disp_state, k);
                end
                checks++;
                if (bro !== ((k == 5) ? vec[7:3] : 5'd0)) begin
                    failures++;
                    $display("FAIL %s bro in D%0d got=%b want=%b", tag, k, bro, (k == 5) ? vec[7:3] : 5'd0);
                end
                step(k == 5, OP_NONE);
                if (k == 3) begin
                    m_if[idx] = 1'b0;
                    checks++;
                    if (if_rdata !== {3'b111, m_if}) begin
                        failures++;
                        $display("FAIL %s if_after_ack got=%h want=%h", tag, if_rdata, {3'b111, m_if});
                    end
                end
            end
            checks++;
            if (disp_state !== 3'd0 || bro !== 5'd0 || ime !== 1'b0) begin
                failures++;
                $display("FAIL %s end_state got=%0d/%b/%b want=0/00000/0", tag, disp_state, bro, ime);
            end
        end
    endtask

    task automatic test_reset();
        #1 RES = 1'b1;
        #1;
        checks++;
        if (if_rdata !== 8'hE0 || ie_rdata !== 8'h00 || ime !== 1'b0 || disp_state !== 3'd0 ||
            bro !== 5'd0 || int_req !== 1'b0 || halted !== 1'b0 || halt_bug !== 1'b0) begin
            failures++;
            $display("FAIL reset got if=%h ie=%h ime=%b st=%0d bro=%b req=%b h=%b hb=%b want E0 00 0 0 0 0 0 0",
                     if_rdata, ie_rdata, ime, disp_state, bro, int_req, halted, halt_bug);
        end
        clk1();
        RES = 1'b0;
        m_if = 5'd0; m_ie = 8'd0; m_ime = 1'b0;
    endtask

    task automatic test_regs();
        logic [7:0] w;
        logic [4:0] s;
        logic       wi, wee;
        for (int n = 0; n < 12; n++) begin
            w = 8'($urandom);
            s = ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'd0;
            wi = 1'($urandom_range(0, 1));
            wee = 1'($urandom_range(0, 1));
            if_we = wi; ie_we = wee; wdata = w; irq_set = s;
            clk1();
            if_we = 1'b0; ie_we = 1'b0; irq_set = 5'd0;
            if (wi) m_if = w[4:0];
            m_if = m_if | s;
            if (wee) m_ie = w;
            checks++;
            if (if_rdata !== {3'b111, m_if} || ie_rdata !== m_ie) begin
                failures++;
                $display("FAIL regs[%0d] got if=%h ie=%h want if=%h ie=%h", n, if_rdata, ie_rdata, {3'b111, m_if}, m_ie);
            end
        end
        op_reti = 1'b1; op_ei = 1'b1; fetch_boundary = 1'b1;
        clk1();
        op_reti = 1'b0; op_ei = 1'b0; fetch_boundary = 1'b0;
        clk1();
        checks++;
        if (ime !== 1'b0) begin
            failures++;
            $display("FAIL ops_without_mstep ime got=%b want=0", ime);
        end
    endtask

    task automatic test_basic();
        write_if(8'h00);
        write_ie(8'h04);
        set_ime(1'b1);
        pulse_set(5'b00100);
        run_dispatch("basic");
        checks++;
        if (if_rdata !== 8'hE0) begin
            failures++;
            $display("FAIL basic if_after got=%h want=E0", if_rdata);
        end
    endtask

    task automatic test_priority();
        write_if(8'h1F);
        write_ie(8'h1F);
        set_ime(1'b1);
        run_dispatch("prio_first");
        set_ime(1'b1);
        run_dispatch("prio_second");
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            write_if(8'($urandom));
            write_ie(8'($urandom));
            set_ime(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) pulse_set(5'($urandom));
            run_dispatch("random");
        end
        set_ime(1'b0);
    endtask

    task automatic test_ei();
        write_if(8'h00);
        write_ie(8'h01);
        pulse_set(5'b00001);
        step(1'b0, OP_EI);
        checks++;
        if (ime !== 1'b0) begin
            failures++;
            $display("FAIL ei_exec ime got=%b want=0", ime);
        end
        step(1'b1, OP_NONE);
        checks++;
        if (last_req !== 1'b0 || ime !== 1'b1) begin
            failures++;
            $display("FAIL ei_boundary req/ime got=%b/%b want=0/1", last_req, ime);
        end
        m_ime = 1'b1;
        run_dispatch("ei_nop");
        pulse_set(5'b00001);
        step(1'b0, OP_EI);
        step(1'b0, OP_DI);
        step(1'b1, OP_NONE);
        checks++;
        if (last_req !== 1'b0) begin
            failures++;
            $display("FAIL ei_di first boundary req got=%b want=0", last_req);
        end
        step(1'b1, OP_NONE);
        checks++;
        if (last_req !== 1'b0 || ime !== 1'b0) begin
            failures++;
            $display("FAIL ei_di second boundary req/ime got=%b/%b want=0/0", last_req, ime);
        end
        m_ime = 1'b0;
    endtask

    task automatic test_cancel();
        logic [4:0] v;
        v = 5'($urandom_range(1, 31));
        write_if({3'b000, v});
        write_ie({3'b000, v});
        set_ime(1'b1);
        step(1'b1, OP_NONE);
        checks++;
        if (last_req !== 1'b1) begin
            failures++;
            $display("FAIL cancel int_req got=%b want=1", last_req);
        end
        step(1'b0, OP_NONE);
        step(1'b0, OP_NONE);
        write_ie(8'h00);
        checks++;
        if (disp_state !== 3'd3) begin
            failures++;
            $display("FAIL cancel hold_d3 got=%0d want=3", disp_state);
        end
        step(1'b0, OP_NONE);
        checks++;
        if (if_rdata !== {3'b111, v}) begin
            failures++;
            $display("FAIL cancel if_kept got=%h want=%h", if_rdata, {3'b111, v});
        end
        step(1'b0, OP_NONE);
        checks++;
        if (bro !== 5'd0 || disp_state !== 3'd5) begin
            failures++;
            $display("FAIL cancel d5 bro/state got=%b/%0d want=00000/5", bro, disp_state);
        end
        step(1'b1, OP_NONE);
        m_ime = 1'b0;
    endtask

    task automatic test_halt();
        set_ime(1'b0);
        write_if(8'h00);
        write_ie(8'h10);
        step(1'b0, OP_HALT);
        checks++;
        if (halted !== 1'b1 || halt_bug !== 1'b0) begin
            failures++;
            $display("FAIL halt_enter h/hb got=%b/%b want=1/0", halted, halt_bug);
        end
        step(1'b1, OP_NONE);
        step(1'b1, OP_NONE);
        pulse_set(5'b10000);
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_hold got=%b want=1", halted);
        end
        step(1'b1, OP_NONE);
        checks++;
        if (halted !== 1'b0 || last_req !== 1'b0 || disp_state !== 3'd0) begin
            failures++;
            $display("FAIL halt_wake h/req/state got=%b/%b/%0d want=0/0/0", halted, last_req, disp_state);
        end
        step(1'b0, OP_HALT);
        checks++;
        if (halted !== 1'b0 || halt_bug !== 1'b1) begin
            failures++;
            $display("FAIL halt_bug set h/hb got=%b/%b want=0/1", halted, halt_bug);
        end
        step(1'b0, OP_NONE);
        checks++;
        if (halt_bug !== 1'b0) begin
            failures++;
            $display("FAIL halt_bug clear got=%b want=0", halt_bug);
        end
        set_ime(1'b1);
        step(1'b0, OP_HALT);
        checks++;
        if (halted !== 1'b0 || halt_bug !== 1'b0) begin
            failures++;
            $display("FAIL halt_ime h/hb got=%b/%b want=0/0", halted, halt_bug);
        end
        run_dispatch("halt_ime");
    endtask

    task automatic test_reset_d4();
        write_if(8'h00);
        write_ie(8'h02);
        pulse_set(5'b00010);
        set_ime(1'b1);
        step(1'b1, OP_NONE);
        step(1'b0, OP_NONE);
        step(1'b0, OP_NONE);
        step(1'b0, OP_NONE);
        checks++;
        if (disp_state !== 3'd4) begin
            failures++;
            $display("FAIL rst_d4 pre state got=%0d want=4", disp_state);
        end
        #2 RES = 1'b1;
        #1;
        checks++;
        if (disp_state !== 3'd0 || bro !== 5'd0 || if_rdata !== 8'hE0 || ie_rdata !== 8'h00 ||
            ime !== 1'b0 || int_req !== 1'b0 || halted !== 1'b0 || halt_bug !== 1'b0) begin
            failures++;
            $display("FAIL rst_d4 outputs st=%0d bro=%b if=%h ie=%h ime=%b req=%b h=%b hb=%b want reset values",
                     disp_state, bro, if_rdata, ie_rdata, ime, int_req, halted, halt_bug);
        end
        clk1();
        RES = 1'b0;
        m_if = 5'd0; m_ie = 8'd0; m_ime = 1'b0;
        write_ie(8'h02);
        pulse_set(5'b00010);
        set_ime(1'b1);
        run_dispatch("after_reset");
    endtask

    initial begin
        test_reset();
        test_regs();
        test_basic();
        test_priority();
        test_random();
        test_ei();
        test_cancel();
        test_halt();
        test_reset_d4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
